qda_dac_update_sched: RTL
=========================

// Module: qda_dac_update_sched
// PURPOSE
//  Multi-channel update scheduler for the QDA serial DAC loaders. Holds one 16-bit setpoint
//  shadow per DAC channel and marks a channel pending on each write. Grants pending channels
//  round-robin, one loader transaction at a time, via an UPDATE pulse, held data and channel select.
//  Sits between the register interface and the per-channel SIN/SCLK/PCLK serial loader mux.
// PARAMETERS
//  N_CH         8    number of DAC channels (2..16)
//  ACK_TIMEOUT  64   max cycles from UPDATE pulse to dac_busy rising before abort
//  GAP_CYCLES   4    idle cycles forced between transactions (0 = none)
// PORTS
//  clk          in   1            system clock, all logic rising-edge
//  rst          in   1            asynchronous, active-high reset
//  wr_en        in   1            setpoint write strobe
//  wr_addr      in   CHW          channel index, CHW=$clog2(N_CH); addr>=N_CH ignored
//  wr_data      in   16           setpoint value
//  update_all   in   1            pulse: mark every channel pending
//  err_clr      in   1            clears err_timeout
//  dac_busy     in   1            loader active (high from accepting UPDATE until PCLK done)
//  dac_update   out  1            one-cycle start pulse to loader
//  dac_data     out  16           REG_DATA to loader, stable from ISSUE until back in IDLE
//  dac_sel      out  CHW          channel routed to loader, stable with dac_data
//  sched_busy   out  1            high in any state except IDLE
//  pending      out  N_CH         per-channel pending flags
//  err_timeout  out  1            sticky: loader failed to acknowledge
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. All outputs 0. Shadows, pending, rr_ptr, counters 0.
//   In-flight transaction is abandoned, not replayed.
//  Write: shadow[wr_addr]<=wr_data, pending[wr_addr]<=1 next edge. Rewriting a pending channel
//   overwrites the shadow; a single transaction sends the latest value.
//  States:
//   IDLE: if |pending: pick first set bit searching from rr_ptr upward mod N_CH. Latch
//     dac_sel and dac_data<=shadow (pre-write value if same-cycle write). Clear that pending bit.
//     rr_ptr<=sel+1 mod N_CH. Go ISSUE. Else stay.
//   ISSUE (1 cycle): dac_update=1; cnt<=0; go WAIT_ACK.
//   WAIT_ACK: dac_busy=1 -> WAIT_DONE; else if cnt==ACK_TIMEOUT-1 -> err_timeout<=1,
//     pending[sel]<=1 (retry later), go GAP; else cnt++.
//   WAIT_DONE: stay while dac_busy; dac_busy=0 -> GAP (cnt<=0). No timeout here.
//   GAP: hold GAP_CYCLES cycles then IDLE; GAP_CYCLES=0 -> IDLE on next cycle (1 cycle total).
//  Grant-to-pulse latency: dac_update asserts exactly 1 cycle after the IDLE grant edge.
//  Pending-set events (write, update_all, timeout requeue) take priority over a same-cycle
//   grant clear: the flag ends set, and the channel is resent with the newer value.
//  Write to the channel in flight: shadow updated, pending set; dac_data/dac_sel unaffected.
//  update_all with writes same cycle: all pending set, write data stored.
//  err_timeout: set wins over same-cycle err_clr. Scheduling continues regardless of error.
//  dac_busy asserted outside WAIT_ACK/WAIT_DONE is ignored.
// TESTING
//  1 Reset, write ch3=0x1234 -> pending=0x08; next cycle ISSUE, dac_update 1 cycle, sel=3,
//    data=0x1234; busy 10 cycles -> GAP 4 -> IDLE, pending=0.
//  2 Write ch1,ch5,ch6 same window, rr_ptr=0 -> grants in order 1,5,6; then write ch0,ch2
//    while ch6 in flight -> next grants 0,2 (rr_ptr wrap from 7).
//  3 Loader never raises dac_busy -> after 64 cycles err_timeout=1, pending[sel]=1,
//    regrant after GAP; err_clr -> err_timeout=0.
//  4 Write ch2=0xAAAA, during its WAIT_DONE write ch2=0x5555 -> first tx 0xAAAA, data held;
//    second tx 0x5555.
//  5 update_all with N_CH=8 -> exactly 8 transactions, sel 0..7, pending=0 at end.
//  6 Assert rst during WAIT_DONE -> outputs 0 immediately; no dac_update after release
//    until a new write.

Source files
------------

// File: rtl/qda_dac_update_sched.sv
// Round-robin update scheduler for the QDA serial DAC loaders: per-channel setpoint
// shadows with pending flags, one loader transaction at a time with ack timeout and gap.
module qda_dac_update_sched #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES  = 4,
  localparam int unsigned CHW        = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [CHW-1:0]  wr_addr,
  input  logic [15:0]     wr_data,
  input  logic            update_all,
  input  logic            err_clr,
  input  logic            dac_busy,
  output logic            dac_update,
  output logic [15:0]     dac_data,
  output logic [CHW-1:0]  dac_sel,
  output logic            sched_busy,
  output logic [N_CH-1:0] pending,
  output logic            err_timeout
);

  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  state_e            state_q;
  logic [15:0]       shadow_q [N_CH];
  logic [N_CH-1:0]   pending_q;
  logic [CHW-1:0]    rr_ptr_q;
  logic [CNTW-1:0]   cnt_q;
  logic [CHW-1:0]    sel_q;
  logic [15:0]       data_q;
  logic              update_q;
  logic              busy_q;
  logic              err_q;

  logic              found_c;
  logic [CHW-1:0]    pick_c;
  logic [CHW-1:0]    idx_c;
  logic              grant_c;
  logic              ack_to_c;
  logic              gap_done_c;
  logic [N_CH-1:0]   wr_oh_c;
  logic [N_CH-1:0]   set_c;
  logic [N_CH-1:0]   clr_c;

  // First pending channel at or above rr_ptr, wrapping modulo N_CH
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx_c = CHW'((32'(rr_ptr_q) + i) % N_CH);
      if (!found_c && pending_q[idx_c]) begin
        found_c = 1'b1;
        pick_c  = idx_c;
      end
    end
  end

  // Set events are OR-ed in after the grant clear so they always win
  always_comb begin
    grant_c    = (state_q == ST_IDLE) && found_c;
    ack_to_c   = (state_q == ST_WAIT_ACK) && !dac_busy && (cnt_q == CNTW'(ACK_TIMEOUT - 1));
    gap_done_c = (GAP_CYCLES <= 1) || (cnt_q == CNTW'(GAP_CYCLES - 1));
    wr_oh_c    = wr_en ? (ONE << wr_addr) : '0;
    set_c      = wr_oh_c | {N_CH{update_all}} | (ack_to_c ? (ONE << sel_q) : '0);
    clr_c      = grant_c ? (ONE << pick_c) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) shadow_q[i] <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_c) | set_c;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (wr_oh_c[i]) shadow_q[i] <= wr_data;
      end
      if (ack_to_c)     err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      update_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (found_c) begin
            sel_q    <= pick_c;
            data_q   <= shadow_q[pick_c];
            rr_ptr_q <= (32'(pick_c) == N_CH - 1) ? '0 : pick_c + CHW'(1);
            update_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (dac_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (ack_to_c) begin
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!dac_busy) begin
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_done_c) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_update  = update_q;
  assign dac_data    = data_q;
  assign dac_sel     = sel_q;
  assign sched_busy  = busy_q;
  assign pending     = pending_q;
  assign err_timeout = err_q;

endmodule
